// File: rtl/pg_flr_scheduler_if.sv
// Port-reset request / reset-FSM sideband bundle of the FLR scheduler.
// master drives the request and handshake side, slave is the scheduler.
interface pg_flr_scheduler_if #(
  parameter int PG_NUM_PORTS = 4,
  parameter int VF_NUM_WIDTH = 11
);
  localparam int IDX_W = (PG_NUM_PORTS > 1) ? $clog2(PG_NUM_PORTS) : 1;

  logic [PG_NUM_PORTS-1:0] i_port_rst_n;
  logic                    i_port_softreset_n;
  logic                    i_err_clr;
  logic                    o_flr_rcvd_vf;
  logic [VF_NUM_WIDTH-1:0] o_flr_rcvd_vf_num;
  logic [PG_NUM_PORTS-1:0] o_flr_done;
  logic                    o_busy;
  logic [PG_NUM_PORTS-1:0] o_pending;
  logic                    o_timeout_err;
  logic [IDX_W-1:0]        o_timeout_port;

  modport master (
    output i_port_rst_n, i_port_softreset_n, i_err_clr,
    input  o_flr_rcvd_vf, o_flr_rcvd_vf_num, o_flr_done, o_busy,
           o_pending, o_timeout_err, o_timeout_port
  );

  modport slave (
    input  i_port_rst_n, i_port_softreset_n, i_err_clr,
    output o_flr_rcvd_vf, o_flr_rcvd_vf_num, o_flr_done, o_busy,
           o_pending, o_timeout_err, o_timeout_port
  );
endinterface

// File: rtl/pg_flr_scheduler.sv
// Queues per-port FLR requests, grants them round-robin onto the single
// VF-FLR sideband and tracks the softreset handshake of each grant.
module pg_flr_scheduler #(
  parameter int PG_NUM_PORTS   = 4,
  parameter int VF_NUM_WIDTH   = 11,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  pg_flr_scheduler_if.slave bus
);
  localparam int IDX_W = (PG_NUM_PORTS > 1) ? $clog2(PG_NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PG_NUM_PORTS - 1);
  localparam logic [IDX_W:0]   NUM_P    = (IDX_W + 1)'(PG_NUM_PORTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ASSERT,
    WAIT_RELEASE,
    DONE
  } state_t;

  state_t                    state, state_next;
  logic [PG_NUM_PORTS-1:0]   prev_rst_n;
  logic [PG_NUM_PORTS-1:0]   pending, pending_next;
  logic [PG_NUM_PORTS-1:0]   fall, grant_clr;
  logic [IDX_W-1:0]          last_grant, start_idx, first, search_idx;
  logic [IDX_W-1:0]          grant, grant_next;
  logic [IDX_W:0]            sum;
  logic [2*PG_NUM_PORTS-1:0] dbl;
  logic [PG_NUM_PORTS-1:0]   rot;
  logic                      search_hit;
  logic                      take_grant;
  logic                      timeout_hit;
  logic [CNT_W-1:0]          cnt, cnt_next;
  logic [VF_NUM_WIDTH-1:0]   vf_num;
  logic                      timeout_err;
  logic [IDX_W-1:0]          timeout_port;

  // Request capture: a new falling edge beats a same-cycle grant clear.
  assign fall         = prev_rst_n & ~bus.i_port_rst_n;
  assign grant_clr    = take_grant ? (PG_NUM_PORTS'(1) << search_idx) : '0;
  assign pending_next = (pending & ~grant_clr) | fall;

  // Rotate pending so bit 0 is the port after last_grant; lowest set bit wins.
  assign start_idx = (last_grant == LAST_IDX) ? '0 : last_grant + IDX_W'(1);
  assign dbl       = {pending, pending} >> start_idx;
  assign rot       = dbl[PG_NUM_PORTS-1:0];

  always_comb begin
    search_hit = |rot;
    first      = '0;
    for (int i = PG_NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) first = IDX_W'(i);
    end
    sum = {1'b0, start_idx} + {1'b0, first};
    if (sum >= NUM_P) sum = sum - NUM_P;
    search_idx = sum[IDX_W-1:0];
  end

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    cnt_next    = cnt;
    take_grant  = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (search_hit) begin
          take_grant = 1'b1;
          grant_next = search_idx;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT_ASSERT;
      end
      // One budget spans both wait phases; a completing handshake beats expiry.
      WAIT_ASSERT: begin
        cnt_next = cnt + CNT_W'(1);
        if (!bus.i_port_softreset_n) begin
          state_next = WAIT_RELEASE;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      WAIT_RELEASE: begin
        cnt_next = cnt + CNT_W'(1);
        if (bus.i_port_softreset_n) begin
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      prev_rst_n   <= '1;
      pending      <= '0;
      last_grant   <= LAST_IDX;
      vf_num       <= '0;
      timeout_err  <= 1'b0;
      timeout_port <= '0;
    end else begin
      state      <= state_next;
      prev_rst_n <= bus.i_port_rst_n;
      pending    <= pending_next;
      if (state == DONE) last_grant <= grant;
      if (take_grant) vf_num <= VF_NUM_WIDTH'(search_idx) + VF_NUM_WIDTH'(1);
      if (timeout_hit) begin
        timeout_err  <= 1'b1;
        timeout_port <= grant;
      end else if (bus.i_err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

  // Grant index and wait counter are always loaded before they are used.
  always_ff @(posedge clk) begin
    grant <= grant_next;
    cnt   <= cnt_next;
  end

  assign bus.o_flr_rcvd_vf     = (state == ISSUE);
  assign bus.o_flr_rcvd_vf_num = vf_num;
  assign bus.o_flr_done        = (state == DONE) ? (PG_NUM_PORTS'(1) << grant) : '0;
  assign bus.o_busy            = (state != IDLE);
  assign bus.o_pending         = pending;
  assign bus.o_timeout_err     = timeout_err;
  assign bus.o_timeout_port    = timeout_port;
endmodule

// File: tb/tb_pg_flr_scheduler.sv
// Scoreboard bench for pg_flr_scheduler: expected VF numbers and done pulses
// are queued as requests are driven and matched as the scheduler emits them.
module tb_pg_flr_scheduler;
  localparam int NP = 4;
  localparam int VW = 11;
  localparam int TO = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pg_flr_scheduler_if #(.PG_NUM_PORTS(NP), .VF_NUM_WIDTH(VW)) bus ();

  pg_flr_scheduler #(
    .PG_NUM_PORTS  (NP),
    .VF_NUM_WIDTH  (VW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int mode = 0;     // 0: normal handshake, 1: no handshake, 2: release on last allowed cycle
  bit in_service = 1'b0;
  int exp_vf[$];
  int exp_done[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reset-FSM model owning the softreset handshake.
  initial begin
    bus.i_port_softreset_n = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && bus.o_flr_rcvd_vf) begin
        if (mode == 0) begin
          repeat (2) @(negedge clk);
          bus.i_port_softreset_n = 1'b0;
          repeat (20) @(negedge clk);
          bus.i_port_softreset_n = 1'b1;
        end else if (mode == 2) begin
          @(negedge clk);
          bus.i_port_softreset_n = 1'b0;
          repeat (TO - 1) @(negedge clk);
          bus.i_port_softreset_n = 1'b1;
        end
      end
    end
  end

  // Output monitor against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_service = 1'b0;
      end else begin
        if (bus.o_flr_rcvd_vf) begin
          chk("strobe_overlap", 32'(in_service), 0);
          if (exp_vf.size() == 0) chk("sb_vf_empty", exp_vf.size(), 1);
          else chk("vf_num", 32'(bus.o_flr_rcvd_vf_num), exp_vf.pop_front());
          in_service = 1'b1;
        end
        if (bus.o_flr_done != '0) begin
          if (exp_done.size() == 0) chk("sb_done_empty", exp_done.size(), 1);
          else chk("done_onehot", 32'(bus.o_flr_done), exp_done.pop_front());
          in_service = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_strobe"}, 32'(bus.o_flr_rcvd_vf), 0);
    chk({tag, "_vfnum"},  32'(bus.o_flr_rcvd_vf_num), 0);
    chk({tag, "_done"},   32'(bus.o_flr_done), 0);
    chk({tag, "_busy"},   32'(bus.o_busy), 0);
    chk({tag, "_pend"},   32'(bus.o_pending), 0);
    chk({tag, "_err"},    32'(bus.o_timeout_err), 0);
    chk({tag, "_eport"},  32'(bus.o_timeout_port), 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.o_busy || bus.o_pending != '0 || exp_vf.size() != 0 ||
                exp_done.size() != 0) && n < 2000);
    chk({tag, "_idle_reached"}, 32'(n < 2000), 1);
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_flr_rcvd_vf && n < 500);
    chk({tag, "_strobe_seen"}, 32'(bus.o_flr_rcvd_vf), 1);
  endtask

  // Counts negedges from the strobe cycle to the done pulse.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_flr_done == '0 && n < 500);
  endtask

  task automatic push(input int vf, input int done_mask);
    exp_vf.push_back(vf);
    if (done_mask != 0) exp_done.push_back(done_mask);
  endtask

  initial begin
    int n;
    bus.i_port_rst_n = '1;
    bus.i_err_clr    = 1'b0;
    reset            = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;

    // Single FLR on port 2
    repeat (10) @(negedge clk);
    push(3, 4'b0100);
    bus.i_port_rst_n[2] = 1'b0;
    @(negedge clk);
    chk("single_pend", 32'(bus.o_pending), 4'b0100);
    chk("single_busy_pre", 32'(bus.o_busy), 0);
    @(negedge clk);
    chk("single_strobe", 32'(bus.o_flr_rcvd_vf), 1);
    chk("single_pend_clr", 32'(bus.o_pending), 0);
    chk("single_busy", 32'(bus.o_busy), 1);
    wait_idle("single");
    @(negedge clk);
    chk("single_busy_after", 32'(bus.o_busy), 0);
    chk("single_vf_hold", 32'(bus.o_flr_rcvd_vf_num), 3);
    bus.i_port_rst_n = '1;

    // Restart so port 0 has first priority, then three simultaneous drops
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("rst2");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push(1, 4'b0001);
    push(2, 4'b0010);
    push(4, 4'b1000);
    bus.i_port_rst_n = 4'b0100;
    @(negedge clk);
    chk("simul_pend", 32'(bus.o_pending), 4'b1011);
    wait_idle("simul");
    bus.i_port_rst_n = '1;
    @(negedge clk);

    // Round-robin: ports 0 and 2 arrive while port 1 is in service
    push(2, 4'b0010);
    bus.i_port_rst_n[1] = 1'b0;
    wait_strobe("rr");
    repeat (3) @(negedge clk);
    push(3, 4'b0100);
    push(1, 4'b0001);
    bus.i_port_rst_n[0] = 1'b0;
    bus.i_port_rst_n[2] = 1'b0;
    @(negedge clk);
    chk("rr_pend", 32'(bus.o_pending), 4'b0101);
    wait_idle("rr");
    bus.i_port_rst_n = '1;
    @(negedge clk);

    // Re-request on port 0 while its handshake is in progress
    push(1, 4'b0001);
    bus.i_port_rst_n[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.i_port_softreset_n && n < 200);
    chk("rereq_sr_low", 32'(bus.i_port_softreset_n), 0);
    repeat (3) @(negedge clk);
    bus.i_port_rst_n[0] = 1'b1;
    @(negedge clk);
    push(1, 4'b0001);
    bus.i_port_rst_n[0] = 1'b0;
    @(negedge clk);
    chk("rereq_pend", 32'(bus.o_pending), 4'b0001);
    wait_done(n);
    chk("rereq_pend_at_done", 32'(bus.o_pending), 4'b0001);
    wait_idle("rereq");
    bus.i_port_rst_n = '1;
    @(negedge clk);

    // Timeout on port 3, then clear
    mode = 1;
    push(4, 4'b1000);
    bus.i_port_rst_n[3] = 1'b0;
    wait_strobe("to");
    wait_done(n);
    chk("to_latency", n, TO + 1);
    chk("to_err", 32'(bus.o_timeout_err), 1);
    chk("to_port", 32'(bus.o_timeout_port), 3);
    @(negedge clk);
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
    chk("to_err_clr", 32'(bus.o_timeout_err), 0);
    chk("to_port_hold", 32'(bus.o_timeout_port), 3);
    bus.i_port_rst_n = '1;
    wait_idle("to");

    // Clear coincident with a new timeout on port 1
    push(2, 4'b0010);
    bus.i_port_rst_n[1] = 1'b0;
    wait_strobe("toclr");
    repeat (TO) @(negedge clk);
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
    chk("toclr_done", 32'(bus.o_flr_done), 4'b0010);
    chk("toclr_err", 32'(bus.o_timeout_err), 1);
    chk("toclr_port", 32'(bus.o_timeout_port), 1);
    @(negedge clk);
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
    bus.i_port_rst_n = '1;
    wait_idle("toclr");

    // Handshake finishing on the very last allowed cycle is not a timeout
    mode = 2;
    push(1, 4'b0001);
    bus.i_port_rst_n[0] = 1'b0;
    wait_strobe("edge");
    wait_done(n);
    chk("edge_latency", n, TO + 1);
    chk("edge_err", 32'(bus.o_timeout_err), 0);
    bus.i_port_rst_n = '1;
    wait_idle("edge");

    // Reset while waiting with two requests still queued
    mode = 1;
    push(2, 0);
    bus.i_port_rst_n = 4'b0001;
    wait_strobe("mid");
    repeat (3) @(negedge clk);
    chk("mid_pend", 32'(bus.o_pending), 4'b1100);
    chk("mid_busy", 32'(bus.o_busy), 1);
    reset = 1'b1;
    mode = 0;
    bus.i_port_rst_n = 4'b0111;
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(negedge clk);
    chk("mid_rst_done", 32'(bus.o_flr_done), 0);
    push(4, 4'b1000);
    reset = 1'b0;
    wait_idle("mid");
    bus.i_port_rst_n = '1;

    repeat (3) @(negedge clk);
    chk("sb_vf_left", exp_vf.size(), 0);
    chk("sb_done_left", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
